sb_trans_parser: RTL
====================

SB_TRANS_PARSER -- requirements
Module: sb_trans_parser

Interface
REQ-001 SHALL have parameter MAX_DATA_BYTES, default 64, maximum AT data bytes per frame (1..127).
REQ-002 SHALL have parameter LEN_W, default 7, width of the length field.
REQ-003 SHALL have parameter CHECK_CRC, default 1, enabling CRC-16 frame checking (0 = CRC bytes consumed, not checked).
REQ-004 SHALL have port sb_clk, input, 1, sideband clock.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port sym_valid, input, 1, one received symbol present this cycle.
REQ-007 SHALL have port sym_data, input, 8, decoded symbol byte.
REQ-008 SHALL have port sym_error, input, 1, framing/parity error on the current symbol.
REQ-009 SHALL have ports tconnect and tdisconnect, input, 1 each, link connect/disconnect events.
REQ-010 SHALL have port at_valid, output, 1, completed AT frame available; at_ready, input, 1, consumer accept.
REQ-011 SHALL have ports at_is_resp (1), at_write (1), at_read (1), at_addr (8), at_len (LEN_W), all outputs describing the frame.
REQ-012 SHALL have ports pl_rd_idx, input, LEN_W, and pl_rd_data, output, 8, combinational payload buffer read port.
REQ-013 SHALL have ports lt_valid (1-cycle pulse) and lt_symbol (8), outputs, for a received LT.
REQ-014 SHALL have ports trans_error (1-cycle pulse), err_code (3), drop_cnt (8), disconnect (1), all outputs.

Function
REQ-015 SHALL act only on cycles with sym_valid=1; all other cycles hold state.
REQ-016 SHALL implement states DISCONNECT, IDLE, DLE1, AT_BODY, AT_DLE, LT_BODY.
REQ-017 SHALL move DISCONNECT->IDLE on tconnect; any state->DISCONNECT on tdisconnect, which wins over all other events.
REQ-018 SHALL transition IDLE->DLE1 on 0xFE; DLE1->AT_BODY on 0x05 (command) or 0x04 (response); DLE1->LT_BODY on 0x80; DLE1 stays on 0xFE; DLE1->IDLE on anything else.
REQ-019 SHALL treat AT body bytes in order: addr, {WnR, len}, len data bytes, CRC low, CRC high.
REQ-020 SHALL transition AT_BODY->AT_DLE on 0xFE; AT_DLE->AT_BODY storing one 0xFE data byte on 0xFE (destuffing); AT_DLE->IDLE on 0x40 (ETX) with frame check; AT_DLE->IDLE with error on any other byte.
REQ-021 SHALL in LT_BODY pulse lt_valid with lt_symbol on the first byte, then return to IDLE on 0x7F (CLSE) or error on any other byte.
REQ-022 SHALL compute CRC-16, polynomial 0x8005, init 0xFFFF, over STX and all destuffed body bytes excluding the CRC bytes.
REQ-023 SHALL on ETX with byte count = len+4, CRC match and no pending frame, assert at_valid in the cycle after ETX.
REQ-024 SHALL hold at_valid and all at_* fields stable until at_valid&&at_ready; at_valid drops the following cycle.
REQ-025 SHALL set at_write=WnR&~at_is_resp, at_read=~WnR&~at_is_resp, both 0 for responses.
REQ-026 SHALL return pl_rd_data=buffer[pl_rd_idx], 0x00 when pl_rd_idx>=at_len.
REQ-027 SHALL pulse trans_error and return to IDLE with err_code: 1 sym_error, 2 len>MAX_DATA_BYTES, 3 byte-count overrun/underrun at ETX, 4 CRC mismatch, 5 bad DLE escape, 6 frame completed while at_valid pending.
REQ-028 SHALL drop errored frames without touching at_* outputs, saturating drop_cnt at 255.
REQ-029 SHALL abort length check immediately when a body byte would exceed len+4 (code 3, no wait for ETX).
REQ-030 SHALL keep disconnect=1 in DISCONNECT and 0 otherwise, registered.

Reset
REQ-031 SHALL on rst low set state DISCONNECT, disconnect=1, all other outputs 0, drop_cnt=0, CRC=0xFFFF.
REQ-032 SHALL not clear the payload buffer on reset; its content is undefined until the first valid frame.
REQ-033 SHALL on reset or tdisconnect mid-frame discard the frame without trans_error.

Structure
REQ-034 SHALL place symbol constants (DLE, STX_CMD, STX_RSP, ETX, LSE, CLSE), the state enum and err_code enum in package sb_pkg.
REQ-035 SHALL instantiate sub-module sb_crc16 (byte-wide, combinational next-CRC).
REQ-036 SHALL implement the buffer as MAX_DATA_BYTES x 8 registers.

Verification
REQ-037 SHALL test write command FE 05 10 83 AA FE FE CC crcL crcH FE 40 -> at_valid, at_addr=0x10, at_len=3, at_write=1, payload AA FE CC.
REQ-038 SHALL test same frame with one CRC bit flipped -> trans_error, err_code=4, drop_cnt=1, no at_valid.
REQ-039 SHALL test len=0x7F with MAX_DATA_BYTES=64 -> err_code=2 on the length byte.
REQ-040 SHALL test second good frame with at_ready=0 -> err_code=6, first frame fields unchanged.
REQ-041 SHALL test FE 80 0x5A 7F -> lt_valid pulse with lt_symbol=0x5A, state IDLE.
REQ-042 SHALL test tdisconnect mid-AT -> state DISCONNECT, disconnect=1, no trans_error.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared symbol constants, parser state and error encodings, and the CRC-16 byte step
// used by the sideband transaction parser.
package sb_pkg;

    localparam logic [7:0]  DLE      = 8'hFE;
    localparam logic [7:0]  STX_CMD  = 8'h05;
    localparam logic [7:0]  STX_RSP  = 8'h04;
    localparam logic [7:0]  ETX      = 8'h40;
    localparam logic [7:0]  LSE      = 8'h80;
    localparam logic [7:0]  CLSE     = 8'h7F;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'h8005;

    typedef enum logic [2:0] {
        ST_DISCONNECT,
        ST_IDLE,
        ST_DLE1,
        ST_AT_BODY,
        ST_AT_DLE,
        ST_LT_BODY
    } sb_state_e;

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_SYM   = 3'd1,
        ERR_LEN   = 3'd2,
        ERR_COUNT = 3'd3,
        ERR_CRC   = 3'd4,
        ERR_ESC   = 3'd5,
        ERR_BUSY  = 3'd6
    } sb_err_e;

    // MSB-first, non-reflected CRC-16 update for one byte.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            c = {c[14:0], 1'b0} ^ ((c[15] ^ data[i]) ? CRC_POLY : 16'h0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/sb_crc16.sv
// Combinational byte-wide CRC-16 next-state step.
module sb_crc16
    import sb_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    always_comb begin
        crc_out = crc16_byte(crc_in, data_in);
    end

endmodule

// File: rtl/sb_trans_parser.sv
// Sideband symbol parser: destuffs AT frames into a payload buffer with length/CRC
// checking, reports LT symbols, and counts dropped frames.
module sb_trans_parser
    import sb_pkg::*;
#(
    parameter int MAX_DATA_BYTES = 64,
    parameter int LEN_W          = 7,
    parameter int CHECK_CRC      = 1
) (
    input  logic             sb_clk,
    input  logic             rst,
    input  logic             sym_valid,
    input  logic [7:0]       sym_data,
    input  logic             sym_error,
    input  logic             tconnect,
    input  logic             tdisconnect,
    output logic             at_valid,
    input  logic             at_ready,
    output logic             at_is_resp,
    output logic             at_write,
    output logic             at_read,
    output logic [7:0]       at_addr,
    output logic [LEN_W-1:0] at_len,
    input  logic [LEN_W-1:0] pl_rd_idx,
    output logic [7:0]       pl_rd_data,
    output logic             lt_valid,
    output logic [7:0]       lt_symbol,
    output logic             trans_error,
    output logic [2:0]       err_code,
    output logic [7:0]       drop_cnt,
    output logic             disconnect
);

    localparam int               CNT_W   = LEN_W + 2;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_DATA_BYTES);

    sb_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      crc_q, crc_d, crc_rx_q, crc_rx_d, crc_nxt;
    logic [7:0]       addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             wnr_q, wnr_d, resp_q, resp_d, taint_q, taint_d;
    logic             at_valid_q, at_valid_d, at_is_resp_q, at_is_resp_d;
    logic             at_write_q, at_write_d, at_read_q, at_read_d;
    logic [7:0]       at_addr_q, at_addr_d;
    logic [LEN_W-1:0] at_len_q, at_len_d;
    logic             lt_valid_q, lt_valid_d, trans_error_q, trans_error_d;
    logic [7:0]       lt_symbol_q, lt_symbol_d, drop_cnt_q, drop_cnt_d;
    logic [2:0]       err_code_q, err_code_d;
    logic             disconnect_q, disconnect_d;
    logic [7:0]       buf_q [MAX_DATA_BYTES];
    logic             buf_we;
    logic [CNT_W-1:0] buf_wa, frame_end;
    logic             len_known, pending;
    logic             start_ev, body_ev, accept_ev, lt_ev;
    sb_err_e          err;

    // Frame length on the wire after destuffing: addr, len byte, data, two CRC bytes.
    assign frame_end = CNT_W'(len_q) + CNT_W'(4);
    assign len_known = (cnt_q >= CNT_W'(2));
    assign pending   = at_valid_q & ~at_ready;

    sb_crc16 u_crc (
        .crc_in  (start_ev ? CRC_INIT : crc_q),
        .data_in (sym_data),
        .crc_out (crc_nxt)
    );

    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_DISCONNECT;
            cnt_q         <= '0;
            crc_q         <= CRC_INIT;
            crc_rx_q      <= '0;
            addr_q        <= '0;
            len_q         <= '0;
            wnr_q         <= 1'b0;
            resp_q        <= 1'b0;
            taint_q       <= 1'b0;
            at_valid_q    <= 1'b0;
            at_is_resp_q  <= 1'b0;
            at_write_q    <= 1'b0;
            at_read_q     <= 1'b0;
            at_addr_q     <= '0;
            at_len_q      <= '0;
            lt_valid_q    <= 1'b0;
            lt_symbol_q   <= '0;
            trans_error_q <= 1'b0;
            err_code_q    <= '0;
            drop_cnt_q    <= '0;
            disconnect_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            crc_q         <= crc_d;
            crc_rx_q      <= crc_rx_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            wnr_q         <= wnr_d;
            resp_q        <= resp_d;
            taint_q       <= taint_d;
            at_valid_q    <= at_valid_d;
            at_is_resp_q  <= at_is_resp_d;
            at_write_q    <= at_write_d;
            at_read_q     <= at_read_d;
            at_addr_q     <= at_addr_d;
            at_len_q      <= at_len_d;
            lt_valid_q    <= lt_valid_d;
            lt_symbol_q   <= lt_symbol_d;
            trans_error_q <= trans_error_d;
            err_code_q    <= err_code_d;
            drop_cnt_q    <= drop_cnt_d;
            disconnect_q  <= disconnect_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        err       = ERR_NONE;
        start_ev  = 1'b0;
        body_ev   = 1'b0;
        accept_ev = 1'b0;
        lt_ev     = 1'b0;
        if (tdisconnect) begin
            state_d = ST_DISCONNECT;
        end else if (state_q == ST_DISCONNECT) begin
            if (tconnect) state_d = ST_IDLE;
        end else if (sym_valid) begin
            if (sym_error) begin
                err     = ERR_SYM;
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: if (sym_data == DLE) state_d = ST_DLE1;
                    ST_DLE1: begin
                        if (sym_data == STX_CMD || sym_data == STX_RSP) begin
                            state_d  = ST_AT_BODY;
                            start_ev = 1'b1;
                        end else if (sym_data == LSE) begin
                            state_d  = ST_LT_BODY;
                            start_ev = 1'b1;
                        end else if (sym_data != DLE) begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_AT_BODY: begin
                        if (sym_data == DLE) state_d = ST_AT_DLE;
                        else body_ev = 1'b1;
                    end
                    ST_AT_DLE: begin
                        state_d = ST_IDLE;
                        if (sym_data == DLE) begin
                            state_d = ST_AT_BODY;
                            body_ev = 1'b1;
                        end else if (sym_data == ETX) begin
                            if (!len_known || cnt_q != frame_end) err = ERR_COUNT;
                            else if (CHECK_CRC != 0 && crc_q != crc_rx_q) err = ERR_CRC;
                            else if (pending || taint_q) err = ERR_BUSY;
                            else accept_ev = 1'b1;
                        end else begin
                            err = ERR_ESC;
                        end
                    end
                    ST_LT_BODY: begin
                        if (cnt_q == '0) begin
                            lt_ev = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            if (sym_data != CLSE) err = ERR_ESC;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
                // Overrun and oversized length abort at the offending byte.
                if (body_ev) begin
                    if (len_known && cnt_q == frame_end) err = ERR_COUNT;
                    else if (cnt_q == CNT_W'(1) && sym_data[LEN_W-1:0] > MAX_LEN) err = ERR_LEN;
                    if (err != ERR_NONE) state_d = ST_IDLE;
                end
            end
        end
    end

    always_comb begin
        cnt_d         = cnt_q;
        crc_d         = crc_q;
        crc_rx_d      = crc_rx_q;
        addr_d        = addr_q;
        len_d         = len_q;
        wnr_d         = wnr_q;
        resp_d        = resp_q;
        taint_d       = taint_q;
        at_valid_d    = at_valid_q & ~at_ready;
        at_is_resp_d  = at_is_resp_q;
        at_write_d    = at_write_q;
        at_read_d     = at_read_q;
        at_addr_d     = at_addr_q;
        at_len_d      = at_len_q;
        lt_valid_d    = 1'b0;
        lt_symbol_d   = lt_symbol_q;
        trans_error_d = 1'b0;
        err_code_d    = err_code_q;
        drop_cnt_d    = drop_cnt_q;
        disconnect_d  = (state_d == ST_DISCONNECT);
        buf_we        = 1'b0;
        buf_wa        = cnt_q - CNT_W'(2);
        if (start_ev) begin
            cnt_d   = '0;
            crc_d   = crc_nxt;
            resp_d  = (sym_data == STX_RSP);
            taint_d = 1'b0;
        end
        if (body_ev && err == ERR_NONE) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!len_known || cnt_q < frame_end - CNT_W'(2)) crc_d = crc_nxt;
            if (cnt_q == '0) begin
                addr_d = sym_data;
            end else if (cnt_q == CNT_W'(1)) begin
                wnr_d = sym_data[7];
                len_d = sym_data[LEN_W-1:0];
            end else if (cnt_q < frame_end - CNT_W'(2)) begin
                // Never overwrite the payload of a frame the consumer has not taken yet.
                if (pending) taint_d = 1'b1;
                else buf_we = 1'b1;
            end else if (cnt_q == frame_end - CNT_W'(2)) begin
                crc_rx_d[7:0] = sym_data;
            end else begin
                crc_rx_d[15:8] = sym_data;
            end
        end
        if (lt_ev) begin
            lt_valid_d  = 1'b1;
            lt_symbol_d = sym_data;
            cnt_d       = cnt_q + CNT_W'(1);
        end
        if (accept_ev) begin
            at_valid_d   = 1'b1;
            at_is_resp_d = resp_q;
            at_write_d   = wnr_q & ~resp_q;
            at_read_d    = ~wnr_q & ~resp_q;
            at_addr_d    = addr_q;
            at_len_d     = len_q;
        end
        if (err != ERR_NONE) begin
            trans_error_d = 1'b1;
            err_code_d    = err;
            if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < MAX_DATA_BYTES; gi++) begin : g_buf
            always_ff @(posedge sb_clk) begin
                if (buf_we && buf_wa == CNT_W'(gi)) buf_q[gi] <= sym_data;
            end
        end
    endgenerate

    always_comb begin
        pl_rd_data = 8'h00;
        for (int i = 0; i < MAX_DATA_BYTES; i++) begin
            if (pl_rd_idx == LEN_W'(i) && pl_rd_idx < at_len_q) pl_rd_data = buf_q[i];
        end
    end

    assign at_valid    = at_valid_q;
    assign at_is_resp  = at_is_resp_q;
    assign at_write    = at_write_q;
    assign at_read     = at_read_q;
    assign at_addr     = at_addr_q;
    assign at_len      = at_len_q;
    assign lt_valid    = lt_valid_q;
    assign lt_symbol   = lt_symbol_q;
    assign trans_error = trans_error_q;
    assign err_code    = err_code_q;
    assign drop_cnt    = drop_cnt_q;
    assign disconnect  = disconnect_q;

endmodule
